// File: rtl/sram_ctrl_seq.sv
// sram_ctrl_seq: sequencer for a small SRAM macro (8 words x 8 bits).
// It takes one request at a time and drives the precharge, decode, write
// and sense phases with programmable durations. It then holds the response
// until the consumer takes it.
module sram_ctrl_seq #(
   parameter int unsigned PRE_CYC   = 1,
   parameter int unsigned SENSE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [2:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic [2:0] dec_a,
   output logic       dec_en,
   output logic       precharge,
   output logic       wr_en,
   output logic [7:0] bl_data,
   output logic       sense_en,
   input  logic [7:0] sense_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRE    = 3'd1,
      ACCESS = 3'd2,
      SENSE  = 3'd3,
      DONE   = 3'd4
   } state_t;

   // The phase counters count down to zero, so an N-cycle phase loads N-1.
   localparam logic [3:0] PRE_LOAD   = 4'(PRE_CYC - 1);
   localparam logic [3:0] SENSE_LOAD = 4'(SENSE_CYC - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic       we_q;
   logic [2:0] addr_q;
   logic [7:0] wdata_q;
   logic       in_idle;

   assign in_idle = (state == IDLE);

   // Outside reset, ready is exactly the IDLE state. It is gated by rst_n
   // so that it reads 0 while reset is asserted and 1 as soon as reset
   // is released, without waiting for a clock edge.
   assign req_ready = rst_n & in_idle;

   // Next-state selection. The phase counter decides when PRE and SENSE end.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid)   state_nxt = PRE;
         PRE:     if (cnt == 4'd0) state_nxt = ACCESS;
         ACCESS:  state_nxt = we_q ? DONE : SENSE;
         SENSE:   if (cnt == 4'd0) state_nxt = DONE;
         DONE:    if (rsp_ready)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, phase counter, captured request and registered array-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= 3'd0;
         wdata_q   <= 8'd0;
         rsp_rdata <= 8'd0;
         rsp_valid <= 1'b0;
         dec_a     <= 3'd0;
         dec_en    <= 1'b0;
         precharge <= 1'b0;
         wr_en     <= 1'b0;
         bl_data   <= 8'd0;
         sense_en  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state <= state_nxt;

         // The counter reloads on every state entry and otherwise counts down.
         if (state_nxt != state) begin
            case (state_nxt)
               PRE:     cnt <= PRE_LOAD;
               SENSE:   cnt <= SENSE_LOAD;
               default: cnt <= 4'd0;
            endcase
         end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         // Capture happens only on the accept edge. Later req_valid pulses
         // cannot disturb an access that is in flight.
         if (in_idle && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end

         // On a write, the response echoes the written data.
         // On a read, it takes the sense-amp value from the last SENSE cycle.
         if (state == ACCESS && state_nxt == DONE)
            rsp_rdata <= wdata_q;
         else if (state == SENSE && state_nxt == DONE)
            rsp_rdata <= sense_data;

         // The outputs are registered from next state, so each one lines up
         // with the state it belongs to. dec_a is loaded on the accept edge
         // and then stays fixed until the access returns to IDLE.
         busy      <= (state_nxt != IDLE);
         precharge <= (state_nxt == PRE);
         dec_en    <= (state_nxt == ACCESS) || (state_nxt == SENSE);
         sense_en  <= (state_nxt == SENSE);
         wr_en     <= (state_nxt == ACCESS) && we_q;
         bl_data   <= ((state_nxt == ACCESS) && we_q) ? wdata_q : 8'd0;
         rsp_valid <= (state_nxt == DONE);
         if (state_nxt == IDLE)
            dec_a <= 3'd0;
         else if (in_idle)
            dec_a <= req_addr;
         else
            dec_a <= addr_q;
      end
   end

endmodule

// File: doc/sram_ctrl_seq.md
SRAM_CTRL_SEQ -- requirements
Module: sram_ctrl_seq

Interface
REQ-001 Parameter PRE_CYC, default 1, SHALL set the bit-line precharge duration in clock cycles (legal 1..15).
REQ-002 Parameter SENSE_CYC, default 2, SHALL set the sense-amplifier enable duration in clock cycles (legal 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 req_valid  input  1  SHALL indicate that a request is offered.
REQ-006 req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 req_we  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-008 req_addr  input  3  SHALL carry the word address.
REQ-009 req_wdata  input  8  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL indicate that an access has completed.
REQ-011 rsp_ready  input  1  SHALL indicate that the response is consumed.
REQ-012 rsp_rdata  output  8  SHALL carry the read data, or the written data for a write.
REQ-013 dec_a  output  3  SHALL drive the 3-to-8 word-line decoder address.
REQ-014 dec_en  output  1  SHALL drive the decoder enable.
REQ-015 precharge  output  1  SHALL drive the bit-line precharge.
REQ-016 wr_en  output  1  SHALL drive the write drivers.
REQ-017 bl_data  output  8  SHALL drive the write-driver data.
REQ-018 sense_en  output  1  SHALL drive the sense-amplifier enable.
REQ-019 sense_data  input  8  SHALL carry the sense-amplifier outputs.
REQ-020 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-021 The block SHALL implement the FSM states IDLE, PRE, ACCESS, SENSE and DONE, with all outputs registered or decoded from registered state only.
REQ-022 In IDLE, req_ready SHALL be 1; a transfer (req_valid & req_ready) SHALL capture req_addr, req_we and req_wdata and move the FSM to PRE.
REQ-023 In PRE, precharge SHALL be 1 and dec_en 0 for exactly PRE_CYC cycles, after which the FSM SHALL enter ACCESS.
REQ-024 In ACCESS, which lasts 1 cycle, dec_en SHALL be 1; for a write, wr_en SHALL be 1 and bl_data SHALL equal the captured wdata, then the FSM SHALL go to DONE; for a read, the FSM SHALL go to SENSE.
REQ-025 In SENSE, dec_en and sense_en SHALL be 1 for SENSE_CYC cycles; on the last of those cycles sense_data SHALL be latched into rsp_rdata, and the FSM SHALL then go to DONE.
REQ-026 dec_a SHALL hold the captured address in every state other than IDLE, and SHALL never change while dec_en is 1.
REQ-027 precharge and dec_en SHALL never be 1 in the same cycle; wr_en and sense_en SHALL never be 1 in the same cycle.
REQ-028 In DONE, rsp_valid SHALL be 1 and SHALL hold, with rsp_rdata stable, until rsp_ready is 1, after which the FSM SHALL return to IDLE on the next edge.
REQ-029 For a write, rsp_rdata SHALL be loaded with the captured wdata on entry to DONE.
REQ-030 req_ready SHALL be 0 in all states other than IDLE; req_valid outside IDLE SHALL be ignored and SHALL NOT alter the captured fields.
REQ-031 With defaults, read latency from the accept edge to rsp_valid SHALL be 5 cycles (PRE 1, ACCESS 1, SENSE 2, then DONE); write latency SHALL be 3 cycles.
REQ-032 If rsp_ready is 1 on the first DONE cycle, rsp_valid SHALL last 1 cycle, and the earliest next accept SHALL be the following cycle.
REQ-033 Phase counters SHALL be 4 bits wide and SHALL reload on each state entry; PRE_CYC or SENSE_CYC equal to 0 is illegal and its behaviour is undefined.

Reset
REQ-034 When rst_n = 0, the FSM SHALL enter IDLE immediately, regardless of the clock.
REQ-035 When rst_n = 0, every output SHALL be 0 immediately, except req_ready, which SHALL be 1 once rst_n deasserts; captured registers and rsp_rdata SHALL clear to 0.
REQ-036 Reset asserted mid-access SHALL abort the access with no response; dec_en, wr_en, sense_en and precharge SHALL drop at once.

Verification
REQ-037 Write addr 3'b101, data 8'hA5, with rsp_ready = 1 -> PRE 1 cycle; then 1 cycle of dec_en = 1, wr_en = 1, dec_a = 5, bl_data = A5; then rsp_valid = 1 with rsp_rdata = A5 at cycle 3.
REQ-038 Read addr 3'b010, with sense_data = 8'h3C during SENSE -> sense_en high 2 cycles; rsp_valid at cycle 5 with rsp_rdata = 3C.
REQ-039 Hold rsp_ready = 0 for 4 cycles in DONE -> rsp_valid and rsp_rdata stable throughout; req_ready = 0; a req_valid pulse offered meanwhile is not captured.
REQ-040 Assert rst_n = 0 during SENSE -> all outputs 0 immediately; after release, IDLE with req_ready = 1 and no rsp_valid.
REQ-041 Back-to-back requests with req_valid held high and PRE_CYC = 3 -> second request accepted 1 cycle after the first response handshake; precharge high exactly 3 cycles per access.
REQ-042 Run all accesses under random stimulus with assertions -> dec_en & precharge never both 1; wr_en & sense_en never both 1; dec_a stable while dec_en is 1.
